// File: rtl/pipeline_pkg.sv
// Types and constants shared between the fetch stage and the pipeline registers.
package pipeline_pkg;
   localparam int unsigned     XLEN      = 32;
   localparam logic [XLEN-1:0] RESET_PC  = '0;
   localparam logic [31:0]     NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pcplus8;
      logic            valid;
   } ifid_t;
endpackage

// File: rtl/pipe_reg_ifid.sv
// IF/ID pipeline register: reset beats flush, flush beats stall, otherwise load.
import pipeline_pkg::*;

module pipe_reg_ifid (
   input  logic  clk,
   input  logic  reset,
   input  logic  stall_i,
   input  logic  flush_i,
   input  ifid_t d_i,
   output ifid_t q_o
);
   ifid_t q_q, q_d;

   // A flush turns the slot into a bubble but leaves pcplus8 untouched.
   always_comb begin
      q_d = q_q;
      if (flush_i) begin
         q_d.instr = NOP_INSTR;
         q_d.valid = 1'b0;
      end else if (!stall_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC selection, IF/ID register and stall/bubble counters.
import pipeline_pkg::*;

module fetch_unit #(
   parameter int unsigned     XLEN     = pipeline_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = pipeline_pkg::RESET_PC,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             BranchTakenE,
   input  logic [XLEN-1:0]  BranchTargetE,
   input  logic             PCSrcW,
   input  logic [XLEN-1:0]  ResultW,
   input  logic             PCSD,
   input  logic             PCSE,
   input  logic             PCSM,
   input  logic [31:0]      InstrF,
   output logic [XLEN-1:0]  ImemAddrF,
   output logic             PCWrPendingF,
   output logic [31:0]      InstrD,
   output logic [XLEN-1:0]  PCPlus8D,
   output logic             ValidD,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] BubbleCount
);
   logic [XLEN-1:0]  pc_q, pc_d, pcplus4;
   logic             pc_en;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   ifid_t            fetch_pkt, dec_pkt;

   assign pcplus4 = pc_q + XLEN'(4);

   // Redirects load even while fetch is stalled; branch target outranks R15 writes.
   always_comb begin
      pc_d = pcplus4;
      if (BranchTakenE)  pc_d = BranchTargetE;
      else if (PCSrcW)   pc_d = ResultW;
      pc_d[1:0] = 2'b00;
   end

   assign pc_en = ~StallF | BranchTakenE | PCSrcW;

   always_ff @(posedge clk) begin
      if (reset)      pc_q <= RESET_PC;
      else if (pc_en) pc_q <= pc_d;
   end

   always_comb begin
      fetch_pkt         = '0;
      fetch_pkt.instr   = InstrF;
      fetch_pkt.pcplus8 = pcplus4 + XLEN'(4);
      fetch_pkt.valid   = 1'b1;
   end

   pipe_reg_ifid u_ifid (
      .clk     (clk),
      .reset   (reset),
      .stall_i (StallD),
      .flush_i (FlushD),
      .d_i     (fetch_pkt),
      .q_o     (dec_pkt)
   );

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (StallF && (stall_cnt_q != '1))  stall_cnt_d  = stall_cnt_q + 1'b1;
      if (FlushD && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ImemAddrF    = pc_q;
   assign PCWrPendingF = PCSD | PCSE | PCSM;
   assign InstrD       = dec_pkt.instr;
   assign PCPlus8D     = dec_pkt.pcplus8;
   assign ValidD       = dec_pkt.valid;
   assign StallCount   = stall_cnt_q;
   assign BubbleCount  = bubble_cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW;
   logic        PCSD, PCSE, PCSM;
   logic [31:0] BranchTargetE, ResultW;
   logic [31:0] InstrF, InstrF2;
   logic [31:0] ImemAddrF, InstrD, PCPlus8D, StallCount, BubbleCount;
   logic        PCWrPendingF, ValidD;
   logic [31:0] ImemAddrF2, InstrD2, PCPlus8D2;
   logic        PCWrPendingF2, ValidD2;
   logic [3:0]  StallCount2, BubbleCount2;

   int unsigned npass = 0;
   int unsigned ntotal = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_pc8;
   logic        m_valid;
   longint      m_sc, m_bc, m_sc4, m_bc4;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0) return 32'hE3A0_0001;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign InstrF  = imem(ImemAddrF);
   assign InstrF2 = imem(ImemAddrF2);

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE), .PCSrcW(PCSrcW),
      .ResultW(ResultW), .PCSD(PCSD), .PCSE(PCSE), .PCSM(PCSM), .InstrF(InstrF),
      .ImemAddrF(ImemAddrF), .PCWrPendingF(PCWrPendingF), .InstrD(InstrD),
      .PCPlus8D(PCPlus8D), .ValidD(ValidD), .StallCount(StallCount),
      .BubbleCount(BubbleCount));

   // Narrow counters make saturation reachable within a short run.
   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE), .PCSrcW(PCSrcW),
      .ResultW(ResultW), .PCSD(PCSD), .PCSE(PCSE), .PCSM(PCSM), .InstrF(InstrF2),
      .ImemAddrF(ImemAddrF2), .PCWrPendingF(PCWrPendingF2), .InstrD(InstrD2),
      .PCPlus8D(PCPlus8D2), .ValidD(ValidD2), .StallCount(StallCount2),
      .BubbleCount(BubbleCount2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic longint sat(input longint v, input longint mx);
      return (v < mx) ? v + 1 : mx;
   endfunction

   task automatic model_clock();
      logic [31:0] p;
      p = m_pc;
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc8 = 32'h0; m_valid = 1'b0;
         m_sc = 0; m_bc = 0; m_sc4 = 0; m_bc4 = 0;
         return;
      end
      if (FlushD) begin
         m_instr = 32'h0; m_valid = 1'b0;
      end else if (!StallD) begin
         m_instr = imem(p); m_pc8 = p + 32'd8; m_valid = 1'b1;
      end
      if (BranchTakenE)  m_pc = BranchTargetE & 32'hFFFF_FFFC;
      else if (PCSrcW)   m_pc = ResultW & 32'hFFFF_FFFC;
      else if (!StallF)  m_pc = p + 32'd4;
      if (StallF) begin
         m_sc = sat(m_sc, 64'hFFFF_FFFF); m_sc4 = sat(m_sc4, 15);
      end
      if (FlushD) begin
         m_bc = sat(m_bc, 64'hFFFF_FFFF); m_bc4 = sat(m_bc4, 15);
      end
   endtask

   task automatic check_all();
      chk("ImemAddrF", ImemAddrF, m_pc);
      chk("InstrD", InstrD, m_instr);
      chk("PCPlus8D", PCPlus8D, m_pc8);
      chk("ValidD", ValidD, m_valid);
      chk("StallCount", StallCount, m_sc);
      chk("BubbleCount", BubbleCount, m_bc);
      chk("PCWrPendingF", PCWrPendingF, PCSD | PCSE | PCSM);
      chk("ImemAddrF_n", ImemAddrF2, m_pc);
      chk("InstrD_n", {InstrD2, PCPlus8D2}, {m_instr, m_pc8});
      chk("ValidD_n", {ValidD2, PCWrPendingF2}, {m_valid, PCSD | PCSE | PCSM});
      chk("StallCount_n", StallCount2, m_sc4);
      chk("BubbleCount_n", BubbleCount2, m_bc4);
   endtask

   task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic bt, input logic [31:0] tgt, input logic pw,
                       input logic [31:0] res);
      reset = r; StallF = sf; StallD = sd; FlushD = fd;
      BranchTakenE = bt; BranchTargetE = tgt; PCSrcW = pw; ResultW = res;
      PCSD = 1'($urandom); PCSE = 1'($urandom); PCSM = 1'($urandom);
      @(posedge clk);
      #1;
      model_clock();
      check_all();
   endtask

   initial begin
      logic [31:0] instr_hold;
      longint      sc_before, bc_before;
      m_pc = '0; m_instr = '0; m_pc8 = '0; m_valid = 1'b0;
      m_sc = 0; m_bc = 0; m_sc4 = 0; m_bc4 = 0;

      // reset and release
      step(1, 1, 1, 1, 1, 32'h44, 1, 32'h88);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_addr", ImemAddrF, 32'h0);
      chk("reset_valid", {ValidD, InstrD, PCPlus8D, StallCount, BubbleCount}, '0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("first_instr", InstrD, 32'hE3A0_0001);
      chk("first_pc8", PCPlus8D, 32'h8);
      chk("first_valid", ValidD, 1'b1);
      chk("seq_addr4", ImemAddrF, 32'h4);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("seq_addr8", ImemAddrF, 32'h8);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("at_0x10", ImemAddrF, 32'h10);

      // three-cycle stall of fetch and decode
      instr_hold = InstrD;
      sc_before = m_sc;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0, 0, 0, 0, 0);
         chk("stall_pc", ImemAddrF, 32'h10);
         chk("stall_instr", InstrD, instr_hold);
      end
      chk("stall_count3", StallCount, 32'(sc_before + 3));
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("resume_0x14", ImemAddrF, 32'h14);

      // branch redirect under stall with flush
      bc_before = m_bc;
      step(0, 1, 0, 1, 1, 32'h200, 0, 0);
      chk("branch_addr", ImemAddrF, 32'h200);
      chk("branch_bubble", {ValidD, InstrD}, 33'h0);
      chk("bubble_inc", BubbleCount, 32'(bc_before + 1));

      step(0, 0, 0, 0, 1, 32'h300, 1, 32'h400);
      chk("branch_beats_w", ImemAddrF, 32'h300);
      step(0, 0, 0, 0, 0, 0, 1, 32'h503);
      chk("w_align", ImemAddrF, 32'h500);
      step(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      chk("at_top", ImemAddrF, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pc_wrap", ImemAddrF, 32'h0);
      chk("pc8_wrap", PCPlus8D, 32'h4);

      // reset in the middle of a stall and a redirect
      step(0, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 32'h700, 1, 32'h800);
      chk("reset_mid", {ImemAddrF, InstrD, PCPlus8D, StallCount, BubbleCount, 1'b0, ValidD}, '0);

      // long stall drives the narrow counter into saturation
      for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 0, 0, 0, 0);
      chk("sat_stall4", StallCount2, 4'hF);
      chk("sat_bubble4", BubbleCount2, 4'hF);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), $urandom,
              ($urandom_range(0, 7) == 0), $urandom);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 5-stage ARM pipeline. It holds the program counter, drives the instruction-memory address, and selects the next PC from sequential, branch (E) or PC-write (W) sources. It registers the fetched instruction into Decode. It consumes StallF, StallD and FlushD from the hazard unit, and produces PCWrPendingF for it. Two saturating counters record stall and bubble cycles for performance debug.

## Interface
- XLEN, 32: datapath/address width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- CNT_W, 32: width of the performance counters.

- clk  in  1  pipeline clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- StallF  in  1  hold PC (from hazard unit).
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  replace IF/ID contents with a bubble.
- BranchTakenE  in  1  branch resolved taken in Execute.
- BranchTargetE  in  XLEN  target of the taken branch (ALUResultE).
- PCSrcW  in  1  instruction in Writeback writes R15.
- ResultW  in  XLEN  value written to R15.
- PCSD, PCSE, PCSM  in  1 each  instruction in D/E/M will write R15.
- InstrF  in  32  instruction memory read data, combinational on ImemAddrF.
- ImemAddrF  out  XLEN  equals PCF.
- PCWrPendingF  out  1  PCSD | PCSE | PCSM.
- InstrD  out  32  registered instruction.
- PCPlus8D  out  XLEN  R15 read value for Decode (fetch PC + 8).
- ValidD  out  1  InstrD is a real instruction, not a bubble.
- StallCount  out  CNT_W  cycles with StallF=1.
- BubbleCount  out  CNT_W  cycles in which FlushD inserted a bubble.

## Operation
- PCPlus4F = PCF + 4, modulo 2^XLEN: wraps silently, no flag.
- Next-PC priority:
  1. BranchTakenE → BranchTargetE.
  2. PCSrcW → ResultW.
  3. Otherwise PCPlus4F.
- PC load enable = ~StallF | BranchTakenE | PCSrcW. A redirect always loads, even while StallF=1.
- PC bits [1:0] are forced to 00 on load. Misaligned targets are truncated.
- IF/ID register priority, evaluated at each clock edge:
  1. reset: InstrD=0, PCPlus8D=0, ValidD=0.
  2. Else FlushD: InstrD=32'h0, ValidD=0. PCPlus8D keeps its old value.
  3. Else StallD: all fields hold.
  4. Else load: InstrD=InstrF, PCPlus8D=PCPlus4F+4, ValidD=1.
- FlushD wins over StallD when both are asserted.
- PCWrPendingF is purely combinational. It is not gated by reset.
- StallCount increments each cycle StallF=1.
- BubbleCount increments each cycle FlushD=1 and reset=0.
- Both counters saturate at all-ones and do not wrap. Reset clears both.

## Timing
- Reset values: PCF=RESET_PC, ImemAddrF=RESET_PC, InstrD=0, PCPlus8D=0, ValidD=0, StallCount=0, BubbleCount=0.
- First cycle after reset deasserts: ImemAddrF=RESET_PC. The instruction at RESET_PC appears on InstrD, with ValidD=1, one cycle later.
- Fetch-to-decode latency is 1 cycle. Memory must return InstrF in the same cycle as ImemAddrF.
- Redirect: BranchTakenE high in cycle n gives ImemAddrF=BranchTargetE in cycle n+1. The hazard unit asserts FlushD in cycle n, so ValidD=0 in n+1.
- BranchTakenE and PCSrcW high together: branch target wins.
- StallF and StallD high for k cycles: PCF and InstrD are frozen for exactly k cycles. StallCount rises by k.
- Reset asserted mid-stall or mid-redirect: reset wins. Every output returns to its reset value the next cycle.

## Structure
- Shared package `pipeline_pkg`: XLEN, RESET_PC default, NOP_INSTR (32'h0), and the `ifid_t` struct {instr, pcplus8, valid}.
- One sub-module: `pipe_reg_ifid`, the IF/ID register with reset/flush/stall priority. It is reused later for ID/EX.
- The PC register, next-PC mux and counters live in the top module.

## Test plan
- Reset release with RESET_PC=0 and InstrF=32'hE3A0_0001:
  - ImemAddrF sequence: 0, 4, 8.
  - InstrD=32'hE3A0_0001 and PCPlus8D=8 one cycle after release.
- StallF=StallD=1 for 3 cycles at PCF=0x10:
  - PCF holds 0x10 and InstrD holds for 3 cycles.
  - StallCount=3.
  - Fetch resumes at 0x14.
- BranchTakenE=1, BranchTargetE=0x200, FlushD=1, StallF=1 in the same cycle:
  - ImemAddrF=0x200 next cycle.
  - ValidD=0 and InstrD=0.
  - BubbleCount increments by 1.
- BranchTakenE=1 (target 0x300) and PCSrcW=1 (ResultW=0x400) together: next ImemAddrF=0x300.
- PCSrcW=1, ResultW=0x503: next ImemAddrF=0x500 (low bits cleared).
- PCF=0xFFFF_FFFC with no stall: next PCF=0x0000_0000.
- StallCount preloaded near all-ones (force) with StallF=1 held: it stays at 0xFFFF_FFFF.
